// File: rtl/id_ex_stage.sv
// ============================================================================
// Module   : id_ex_stage
// Brief    : ID/EX pipeline register with RAW hazard stall, flush and WB bypass.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 9,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic              stall_o,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [XLEN-1:0]   ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic              r_valid;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_rs1_data;
    logic [XLEN-1:0]   r_rs2_data;
    logic [XLEN-1:0]   r_imm;
    logic [4:0]        r_rs1;
    logic [4:0]        r_rs2;
    logic [4:0]        r_rd;
    logic [CTRL_W-1:0] r_ctrl;
    logic [CNT_W-1:0]  r_stall_count;

    logic              w_rs1_match;
    logic              w_rs2_match;
    logic              w_hazard;
    logic              w_stall;
    logic              w_bubble;
    logic              w_byp_rs1;
    logic              w_byp_rs2;
    logic [XLEN-1:0]   w_rs1_data;
    logic [XLEN-1:0]   w_rs2_data;

    // No EX/MEM forwarding exists, so any read of the EX producer's rd must wait one cycle.
    assign w_rs1_match = id_uses_rs1 && (r_rd == id_rs1);
    assign w_rs2_match = id_uses_rs2 && (r_rd == id_rs2);
    assign w_hazard    = id_valid && r_valid && r_ctrl[0] && (r_rd != 5'd0)
                         && (w_rs1_match || w_rs2_match);
    assign w_stall     = w_hazard && !flush && !rst;
    assign w_bubble    = flush || w_stall || !id_valid;

    // Register file is read before WB writes it this cycle; patch the stale value in.
    assign w_byp_rs1  = wb_reg_write && (wb_rd != 5'd0) && (wb_rd == id_rs1);
    assign w_byp_rs2  = wb_reg_write && (wb_rd != 5'd0) && (wb_rd == id_rs2);
    assign w_rs1_data = w_byp_rs1 ? wb_data : id_rs1_data;
    assign w_rs2_data = w_byp_rs2 ? wb_data : id_rs2_data;

    always_ff @(posedge clk) begin
        if (rst || w_bubble) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_ctrl     <= '0;
        end else begin
            r_valid    <= 1'b1;
            r_pc       <= id_pc;
            r_rs1_data <= w_rs1_data;
            r_rs2_data <= w_rs2_data;
            r_imm      <= id_imm;
            r_rs1      <= id_rs1;
            r_rs2      <= id_rs2;
            r_rd       <= id_rd;
            r_ctrl     <= id_ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != c_CNT_MAX)) begin
            r_stall_count <= r_stall_count + c_CNT_ONE;
        end
    end

    assign stall_o     = w_stall;
    assign ex_valid    = r_valid;
    assign ex_pc       = r_pc;
    assign ex_rs1_data = r_rs1_data;
    assign ex_rs2_data = r_rs2_data;
    assign ex_imm      = r_imm;
    assign ex_rs1      = r_rs1;
    assign ex_rs2      = r_rs2;
    assign ex_rd       = r_rd;
    assign ex_ctrl     = r_ctrl;
    assign stall_count = r_stall_count;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// Module   : tb_id_ex_stage
// Brief    : Scoreboard bench for id_ex_stage (CNT_W reduced to 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 9;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid;
    logic [XLEN-1:0]   id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]        id_rs1, id_rs2, id_rd;
    logic              id_uses_rs1, id_uses_rs2;
    logic [CTRL_W-1:0] id_ctrl;
    logic              wb_reg_write;
    logic [4:0]        wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              flush;
    logic              stall_o;
    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]        ex_rs1, ex_rs2, ex_rd;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [CNT_W-1:0]  stall_count;

    id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_ctrl(id_ctrl),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .stall_o(stall_o), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              v;
        logic [XLEN-1:0]   pc, d1, d2, imm;
        logic [4:0]        rs1, rs2, rd;
        logic              u1, u2;
        logic [CTRL_W-1:0] ctrl;
        logic              wbw;
        logic [4:0]        wbrd;
        logic [XLEN-1:0]   wbd;
        logic              fl;
        logic              rst;
    } in_t;

    typedef struct {
        logic              v;
        logic [XLEN-1:0]   pc, d1, d2, imm;
        logic [4:0]        rs1, rs2, rd;
        logic [CTRL_W-1:0] ctrl;
        logic [CNT_W-1:0]  cnt;
    } ex_t;

    int  n_checks = 0;
    int  n_errors = 0;
    ex_t sb_q[$];
    ex_t m;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic in_t ins(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic [CTRL_W-1:0] ctrl);
        in_t s;
        s.v = 1'b1; s.pc = $urandom; s.d1 = $urandom; s.d2 = $urandom; s.imm = $urandom;
        s.rs1 = rs1; s.rs2 = rs2; s.rd = rd; s.u1 = u1; s.u2 = u2; s.ctrl = ctrl;
        s.wbw = 1'b0; s.wbrd = 5'd0; s.wbd = $urandom; s.fl = 1'b0; s.rst = 1'b0;
        return s;
    endfunction

    // Reference model: next EX contents from current model state and ID/WB inputs.
    function automatic ex_t model(input in_t s, input ex_t cur, output logic stall);
        ex_t n;
        logic hz;
        hz = s.v && cur.v && cur.ctrl[0] && (cur.rd != 0) &&
             ((s.u1 && cur.rd == s.rs1) || (s.u2 && cur.rd == s.rs2));
        stall = hz && !s.fl && !s.rst;
        n = '{v: 1'b0, pc: '0, d1: '0, d2: '0, imm: '0, rs1: '0, rs2: '0, rd: '0, ctrl: '0, cnt: cur.cnt};
        if (s.rst) begin
            n.cnt = '0;
        end else if (!(s.fl || stall || !s.v)) begin
            n.v = 1'b1; n.pc = s.pc; n.imm = s.imm;
            n.rs1 = s.rs1; n.rs2 = s.rs2; n.rd = s.rd; n.ctrl = s.ctrl;
            n.d1 = (s.wbw && s.wbrd != 0 && s.wbrd == s.rs1) ? s.wbd : s.d1;
            n.d2 = (s.wbw && s.wbrd != 0 && s.wbrd == s.rs2) ? s.wbd : s.d2;
        end
        if (stall && n.cnt != {CNT_W{1'b1}}) n.cnt = n.cnt + 1'b1;
        return n;
    endfunction

    task automatic step(input in_t s);
        ex_t  e, o;
        logic st;
        @(negedge clk);
        id_valid = s.v; id_pc = s.pc; id_rs1_data = s.d1; id_rs2_data = s.d2; id_imm = s.imm;
        id_rs1 = s.rs1; id_rs2 = s.rs2; id_rd = s.rd; id_uses_rs1 = s.u1; id_uses_rs2 = s.u2;
        id_ctrl = s.ctrl; wb_reg_write = s.wbw; wb_rd = s.wbrd; wb_data = s.wbd;
        flush = s.fl; rst = s.rst;
        e = model(s, m, st);
        #1;
        if (!s.rst) chk("stall_o", 64'(stall_o), 64'(st));
        else        chk("stall_o_rst", 64'(stall_o), 64'd0);
        sb_q.push_back(e);
        m = e;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
        end else begin
            o = sb_q.pop_front();
            chk("ex_valid", 64'(ex_valid), 64'(o.v));
            chk("ex_pc", 64'(ex_pc), 64'(o.pc));
            chk("ex_rs1_data", 64'(ex_rs1_data), 64'(o.d1));
            chk("ex_rs2_data", 64'(ex_rs2_data), 64'(o.d2));
            chk("ex_imm", 64'(ex_imm), 64'(o.imm));
            chk("ex_rs1", 64'(ex_rs1), 64'(o.rs1));
            chk("ex_rs2", 64'(ex_rs2), 64'(o.rs2));
            chk("ex_rd", 64'(ex_rd), 64'(o.rd));
            chk("ex_ctrl", 64'(ex_ctrl), 64'(o.ctrl));
            chk("stall_count", 64'(stall_count), 64'(o.cnt));
        end
    endtask

    initial begin
        in_t s;
        m = '{v: 1'b0, pc: '0, d1: '0, d2: '0, imm: '0, rs1: '0, rs2: '0, rd: '0, ctrl: '0, cnt: '0};

        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            s = ins(5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 9'($urandom));
            s.wbw = 1'($urandom); s.wbrd = 5'($urandom); s.fl = 1'($urandom); s.rst = 1'b1;
            step(s);
        end
        chk("reset_valid", 64'(ex_valid), 64'd0);
        chk("reset_count", 64'(stall_count), 64'd0);

        // Independent stream
        step(ins(5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 9'h001));
        chk("indep_rd5", 64'(ex_rd), 64'd5);
        step(ins(5'd6, 5'd3, 5'd4, 1'b1, 1'b1, 9'h001));
        chk("indep_rd6", 64'(ex_rd), 64'd6);

        // RAW: add x5 then sub x7,x5,x2 -> one bubble, then sub loads
        step(ins(5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 9'h001));
        s = ins(5'd7, 5'd5, 5'd2, 1'b1, 1'b1, 9'h005);
        step(s);
        chk("raw_bubble_valid", 64'(ex_valid), 64'd0);
        chk("raw_bubble_rd", 64'(ex_rd), 64'd0);
        step(s);
        chk("raw_load_rd", 64'(ex_rd), 64'd7);
        chk("raw_count", 64'(stall_count), 64'd1);

        // x0 producer and unused source never stall
        step(ins(5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 9'h001));
        step(ins(5'd8, 5'd0, 5'd0, 1'b1, 1'b1, 9'h001));
        step(ins(5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 9'h001));
        step(ins(5'd9, 5'd5, 5'd5, 1'b0, 1'b0, 9'h001));
        chk("nouse_valid", 64'(ex_valid), 64'd1);

        // Load producer (mem_read) also needs one bubble, via rs2
        step(ins(5'd10, 5'd1, 5'd2, 1'b1, 1'b1, 9'h003));
        step(ins(5'd11, 5'd3, 5'd10, 1'b1, 1'b1, 9'h001));
        chk("load_raw_count", 64'(stall_count), 64'd2);

        // WB bypass on both sources, then x0 never bypasses
        s = ins(5'd12, 5'd9, 5'd9, 1'b1, 1'b1, 9'h001);
        s.d1 = 32'h11; s.d2 = 32'h11; s.wbw = 1'b1; s.wbrd = 5'd9; s.wbd = 32'hDEADBEEF;
        step(s);
        chk("byp_rs1", 64'(ex_rs1_data), 64'hDEADBEEF);
        chk("byp_rs2", 64'(ex_rs2_data), 64'hDEADBEEF);
        s.wbrd = 5'd0;
        step(s);
        chk("nobyp_rs1", 64'(ex_rs1_data), 64'h11);

        // Flush beats hazard
        step(ins(5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 9'h001));
        s = ins(5'd7, 5'd5, 5'd2, 1'b1, 1'b1, 9'h001);
        s.fl = 1'b1;
        step(s);
        chk("flush_valid", 64'(ex_valid), 64'd0);
        chk("flush_count", 64'(stall_count), 64'd2);
        step(ins(5'd13, 5'd5, 5'd6, 1'b1, 1'b1, 9'h001));
        chk("after_flush_rd", 64'(ex_rd), 64'd13);

        // Saturation: 20 producer/consumer pairs, each costing one stall
        for (int i = 0; i < 20; i++) begin
            step(ins(5'd20, 5'd1, 5'd2, 1'b1, 1'b1, 9'h001));
            step(ins(5'd21, 5'd20, 5'd2, 1'b1, 1'b0, 9'h001));
        end
        chk("sat_count", 64'(stall_count), 64'd15);

        // Random traffic over a small register window to mix hazards, bypasses and flushes
        for (int i = 0; i < 40; i++) begin
            s = ins(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom), 1'($urandom), 9'($urandom));
            s.v = ($urandom_range(0, 5) != 0);
            s.wbw = 1'($urandom); s.wbrd = 5'($urandom_range(0, 3));
            s.fl = ($urandom_range(0, 7) == 0);
            step(s);
        end

        // Reset mid-stall clears and adds no count
        step(ins(5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 9'h001));
        s = ins(5'd7, 5'd5, 5'd2, 1'b1, 1'b1, 9'h001);
        s.rst = 1'b1;
        step(s);
        chk("rst_count", 64'(stall_count), 64'd0);
        chk("rst_valid", 64'(ex_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
